amp_supervisor: RTL and testbench
=================================

// Module: amp_supervisor
// PURPOSE
//  Parametrised power/mute/fault sequencer for NUM_AMPS class-D amplifiers driven by the I2S frontend.
//  Generalises the single-amp startup logic: per-amp glitch-filtered error detection, bounded
//  automatic retry, latched fault, pop-free mute-before-disable shutdown and saturating clip counters.
//  Sits between the rx/I2S stream decoder (stream lock) and the amplifier control pins.
// PARAMETERS
//  NUM_AMPS   2    number of independent amplifier channels
//  TMR_W      20   width of the sequencing timer
//  T_ENABLE   1000 cycles from enable (nenable low) to unmute
//  T_MUTE     500  cycles from mute to disable on orderly shutdown
//  T_RETRY    5000 back-off cycles in RECOVER before re-enabling
//  ERR_FILT   4    consecutive low samples of synchronised nerror needed to count as error
//  MAX_RETRY  3    recover attempts before fault is latched (1..15)
//  CLIP_W     16   width of each clip counter
// PORTS
//  clk           in   1            system clock (100 MHz)
//  reset         in   1            one clock; reset is asynchronous and active-low
//  run           in   1            host request: amplifiers on
//  stream_lock   in   1            I2S stream valid from frontend decoder
//  nerror_in     in   NUM_AMPS     amp error pins, async, active-low
//  nclip_in      in   NUM_AMPS     amp clip pins, async, active-low
//  clip_clear    in   1            synchronous clear of all clip counters
//  nenable_out   out  NUM_AMPS     amp enable, active-low
//  nmute_out     out  NUM_AMPS     amp mute, active-low (1 = audio passes)
//  fault_out     out  NUM_AMPS     retries exhausted, latched
//  state_out     out  3*NUM_AMPS   per-amp FSM state, amp i in bits [3i+2:3i]
//  retry_out     out  4*NUM_AMPS   per-amp retry count
//  clip_cnt_out  out  CLIP_W*NUM_AMPS  per-amp saturating clip-edge count
// BEHAVIOUR
//  Reset (async, immediate): nenable_out all 1, nmute_out all 0, fault/retry/clip 0, state OFF.
//  nerror_in/nclip_in pass through 2-flop synchronisers; all decisions on synchronised values.
//  Error = synchronised nerror low for ERR_FILT consecutive cycles; any high sample restarts filter.
//  Per-amp FSM (independent; one amp never affects another):
//   OFF(0): nenable=1,nmute=0; run&stream_lock -> POWERUP, retry cleared on OFF entry.
//   POWERUP(1): nenable=0,nmute=0; timer T_ENABLE cycles -> RUN; error -> RECOVER;
//     !run|!lock -> OFF.
//   RUN(2): nenable=0,nmute=1; error -> RECOVER; !run|!lock -> MUTE. Error wins if simultaneous.
//   MUTE(3): nenable=0,nmute=0; T_MUTE cycles -> OFF; error -> OFF at once. Lock return ignored
//     (always completes to OFF, then restarts normally).
//   RECOVER(4): nenable=1,nmute=0; retry+1 on entry; after T_RETRY cycles: retry<MAX_RETRY ->
//     POWERUP else LATCHED. !run -> OFF.
//   LATCHED(5): nenable=1,nmute=0,fault=1; only !run -> OFF (fault cleared). Unused codes -> OFF.
//  Latency: state change registered one cycle after condition; nmute/nenable are registered
//   decodes of state (glitch-free). Error response: nenable high 3+ERR_FILT cycles after first low.
//  Timer loads 0 on every state entry; T_* values must fit TMR_W (compile-time check).
//  Clip: falling edge of synchronised nclip, counted only in RUN; saturates at 2^CLIP_W-1;
//   clip_clear zeroes all; clear and edge same cycle -> count = 1.
// STRUCTURE
//  amp_supervisor_defs.vh: state encodings (ST_OFF..ST_LATCHED), 3-bit state width.
//  Sub-module amp_channel_seq: sync, error filter, FSM, timer, retry, clip counter for one amp;
//   instantiated NUM_AMPS times in a generate loop. Top holds only fan-out and output packing.
// TESTING (NUM_AMPS=2, T_ENABLE=100, T_MUTE=50, T_RETRY=200, ERR_FILT=4, MAX_RETRY=3, CLIP_W=4)
//  Startup: run=1,lock=1 -> nenable_out=2'b00 next cycle; nmute_out=2'b11 exactly 100 cycles later.
//  Glitch: nerror_in[0] low 3 cycles in RUN -> no change; low 5 cycles -> amp0 RECOVER,
//   nenable_out=2'b01, amp1 stays RUN with nmute_out[1]=1.
//  Persistent: nerror_in[1] held low -> 3 RECOVER passes, then fault_out=2'b10, retry_out[7:4]=3;
//   run=0 -> amp1 OFF, fault cleared, retry 0.
//  Lock loss in RUN: nmute_out=0 after 1 cycle, nenable_out=1 after 50 more; lock back at MUTE
//   cycle 20 -> still OFF, then POWERUP next cycle.
//  Clip: 7 pulses (2 cycles low) -> clip count 7; clear with coincident pulse -> 1; 20 pulses -> 15.
//  Async reset asserted mid-RUN -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/amp_supervisor_pkg.sv
// Shared types and helpers for the amplifier power/mute/fault sequencer.
package amp_supervisor_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned RetryW = 4;

    // Per-amp sequencer state; the numeric codes are visible on state_out.
    typedef enum logic [StateW-1:0] {
        StOff     = 3'd0,
        StPowerup = 3'd1,
        StRun     = 3'd2,
        StMute    = 3'd3,
        StRecover = 3'd4,
        StLatched = 3'd5
    } amp_state_e;

    // The amp is held enabled (pin low) only while powering, running or muting;
    // every other code, including unused ones, releases the enable pin.
    function automatic logic nenable_of(amp_state_e st);
        logic pin;
        case (st)
            StPowerup, StRun, StMute: pin = 1'b0;
            default:                  pin = 1'b1;
        endcase
        return pin;
    endfunction

    // True when value is representable in an unsigned field of the given width.
    function automatic logic fits_width(longint unsigned value, int unsigned width);
        return (width >= 63) || (value < (64'd1 << width));
    endfunction

endpackage

// File: rtl/amp_supervisor_channel.sv
// One amplifier channel: pin synchronisers, error glitch filter, power/mute FSM,
// sequencing timer, bounded retry counter and saturating clip-edge counter.
module amp_supervisor_channel
    import amp_supervisor_pkg::*;
#(
    parameter int unsigned TMR_W     = 20,
    parameter int unsigned T_ENABLE  = 1000,
    parameter int unsigned T_MUTE    = 500,
    parameter int unsigned T_RETRY   = 5000,
    parameter int unsigned ERR_FILT  = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CLIP_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              stream_lock,
    input  logic              nerror_in,
    input  logic              nclip_in,
    input  logic              clip_clear,
    output logic              nenable_out,
    output logic              nmute_out,
    output logic              fault_out,
    output logic [StateW-1:0] state_out,
    output logic [RetryW-1:0] retry_out,
    output logic [CLIP_W-1:0] clip_cnt_out
);

    localparam int unsigned FiltW = (ERR_FILT > 1) ? $clog2(ERR_FILT) : 1;

    localparam logic [FiltW-1:0]  FiltLast   = FiltW'(ERR_FILT - 1);
    localparam logic [TMR_W-1:0]  EnableLast = TMR_W'(T_ENABLE - 1);
    localparam logic [TMR_W-1:0]  MuteLast   = TMR_W'(T_MUTE - 1);
    localparam logic [TMR_W-1:0]  RetryLast  = TMR_W'(T_RETRY - 1);
    localparam logic [RetryW-1:0] RetryLimit = RetryW'(MAX_RETRY);
    localparam logic [CLIP_W-1:0] ClipMax    = '1;

    // Elaboration-time parameter sanity checks.
    if (!fits_width(T_ENABLE, TMR_W) || !fits_width(T_MUTE, TMR_W)
        || !fits_width(T_RETRY, TMR_W)) begin : g_tmr_check
        $error("amp_supervisor_channel: T_ENABLE/T_MUTE/T_RETRY must fit in TMR_W bits");
    end
    if (T_ENABLE < 1 || T_MUTE < 1 || T_RETRY < 1) begin : g_tmr_zero_check
        $error("amp_supervisor_channel: sequencing intervals must be at least one cycle");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_retry_check
        $error("amp_supervisor_channel: MAX_RETRY must be in 1..15");
    end
    if (ERR_FILT < 1) begin : g_filt_check
        $error("amp_supervisor_channel: ERR_FILT must be at least 1");
    end

    logic              nerr_meta_q, nerr_sync_q;
    logic              nclip_meta_q, nclip_sync_q, nclip_prev_q;
    logic [FiltW-1:0]  err_cnt_q, err_cnt_d;
    logic              err_det;
    amp_state_e        state_q, state_d;
    logic              stop_req;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              clip_edge;
    logic [CLIP_W-1:0] clip_q, clip_d;
    logic              nenable_q, nmute_q, fault_q;

    // Two-flop synchronisers for the asynchronous pins; both idle high out of reset
    // so release of reset never looks like an error or a clip edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nerr_meta_q  <= 1'b1;
            nerr_sync_q  <= 1'b1;
            nclip_meta_q <= 1'b1;
            nclip_sync_q <= 1'b1;
            nclip_prev_q <= 1'b1;
        end else begin
            nerr_meta_q  <= nerror_in;
            nerr_sync_q  <= nerr_meta_q;
            nclip_meta_q <= nclip_in;
            nclip_sync_q <= nclip_meta_q;
            nclip_prev_q <= nclip_sync_q;
        end
    end

    // Error filter: the current low sample plus ERR_FILT-1 earlier consecutive lows.
    assign err_det  = !nerr_sync_q && (err_cnt_q == FiltLast);
    assign stop_req = !run || !stream_lock;

    // Next state; error has priority over a stop request in POWERUP and RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff: begin
                if (run && stream_lock) state_d = StPowerup;
            end
            StPowerup: begin
                if (err_det)                  state_d = StRecover;
                else if (stop_req)            state_d = StOff;
                else if (tmr_q == EnableLast) state_d = StRun;
            end
            StRun: begin
                if (err_det)       state_d = StRecover;
                else if (stop_req) state_d = StMute;
            end
            StMute: begin
                // Lock return is ignored: an orderly shutdown always completes.
                if (err_det || tmr_q == MuteLast) state_d = StOff;
            end
            StRecover: begin
                if (!run) begin
                    state_d = StOff;
                end else if (tmr_q == RetryLast) begin
                    state_d = (retry_q < RetryLimit) ? StPowerup : StLatched;
                end
            end
            StLatched: begin
                if (!run) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StOff;
        else        state_q <= state_d;
    end

    // Datapath next values: filter, entry-cleared timer, retry count, clip counter.
    always_comb begin
        err_cnt_d = err_cnt_q;
        tmr_d     = tmr_q;
        retry_d   = retry_q;
        clip_d    = clip_q;

        if (nerr_sync_q)                err_cnt_d = '0;
        else if (err_cnt_q != FiltLast) err_cnt_d = err_cnt_q + 1'b1;

        if (state_d != state_q) tmr_d = '0;
        else if (tmr_q != '1)   tmr_d = tmr_q + 1'b1;

        if (state_d != state_q) begin
            if (state_d == StOff)                            retry_d = '0;
            else if (state_d == StRecover && retry_q != '1)  retry_d = retry_q + 1'b1;
        end

        // A clear coinciding with an edge leaves exactly that one edge counted.
        clip_edge = nclip_prev_q && !nclip_sync_q && (state_q == StRun);
        if (clip_clear)                         clip_d = CLIP_W'(clip_edge);
        else if (clip_edge && clip_q != ClipMax) clip_d = clip_q + 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            tmr_q     <= '0;
            retry_q   <= '0;
            clip_q    <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            tmr_q     <= tmr_d;
            retry_q   <= retry_d;
            clip_q    <= clip_d;
        end
    end

    // Amp control pins are registered decodes of the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nenable_q <= 1'b1;
            nmute_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            nenable_q <= nenable_of(state_q);
            nmute_q   <= (state_q == StRun);
            fault_q   <= (state_q == StLatched);
        end
    end

    assign nenable_out  = nenable_q;
    assign nmute_out    = nmute_q;
    assign fault_out    = fault_q;
    assign state_out    = state_q;
    assign retry_out    = retry_q;
    assign clip_cnt_out = clip_q;

endmodule

// File: rtl/amp_supervisor.sv
// Power/mute/fault supervisor for NUM_AMPS class-D amplifiers: fans the shared
// run/lock/clear controls out to independent per-amp sequencers and packs their outputs.
module amp_supervisor
    import amp_supervisor_pkg::*;
#(
    parameter int unsigned NUM_AMPS  = 2,
    parameter int unsigned TMR_W     = 20,
    parameter int unsigned T_ENABLE  = 1000,
    parameter int unsigned T_MUTE    = 500,
    parameter int unsigned T_RETRY   = 5000,
    parameter int unsigned ERR_FILT  = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned CLIP_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         stream_lock,
    input  logic [NUM_AMPS-1:0]          nerror_in,
    input  logic [NUM_AMPS-1:0]          nclip_in,
    input  logic                         clip_clear,
    output logic [NUM_AMPS-1:0]          nenable_out,
    output logic [NUM_AMPS-1:0]          nmute_out,
    output logic [NUM_AMPS-1:0]          fault_out,
    output logic [StateW*NUM_AMPS-1:0]   state_out,
    output logic [RetryW*NUM_AMPS-1:0]   retry_out,
    output logic [CLIP_W*NUM_AMPS-1:0]   clip_cnt_out
);

    if (NUM_AMPS < 1) begin : g_amps_check
        $error("amp_supervisor: NUM_AMPS must be at least 1");
    end

    // One fully independent sequencer per amplifier.
    for (genvar i = 0; i < NUM_AMPS; i++) begin : g_amp
        amp_supervisor_channel #(
            .TMR_W     (TMR_W),
            .T_ENABLE  (T_ENABLE),
            .T_MUTE    (T_MUTE),
            .T_RETRY   (T_RETRY),
            .ERR_FILT  (ERR_FILT),
            .MAX_RETRY (MAX_RETRY),
            .CLIP_W    (CLIP_W)
        ) u_chan (
            .clk          (clk),
            .rst_n        (reset),
            .run          (run),
            .stream_lock  (stream_lock),
            .nerror_in    (nerror_in[i]),
            .nclip_in     (nclip_in[i]),
            .clip_clear   (clip_clear),
            .nenable_out  (nenable_out[i]),
            .nmute_out    (nmute_out[i]),
            .fault_out    (fault_out[i]),
            .state_out    (state_out[StateW*i +: StateW]),
            .retry_out    (retry_out[RetryW*i +: RetryW]),
            .clip_cnt_out (clip_cnt_out[CLIP_W*i +: CLIP_W])
        );
    end

endmodule

// File: tb/tb_amp_supervisor.sv
// Scoreboard bench for amp_supervisor: stimulus pushes each expected output change
// (full output snapshot plus the cycle it must appear on); a monitor pops one entry
// each time the packed outputs change and flags missing or unexpected changes.
module tb_amp_supervisor;

    localparam int unsigned ObsW = 3*2 + 2 + 2 + 2 + 4*2 + 4*2;

    typedef struct {
        int               cyc;
        logic [ObsW-1:0]  obs;
        string            name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       stream_lock = 1'b0;
    logic       clip_clear = 1'b0;
    logic [1:0] nerror_in = 2'b11;
    logic [1:0] nclip_in = 2'b11;
    logic [1:0] nenable_out, nmute_out, fault_out;
    logic [5:0] state_out;
    logic [7:0] retry_out, clip_cnt_out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [ObsW-1:0] last_obs = 'x;

    // Expected-output model, edited by hand before each push.
    logic [2:0] m_state [2];
    logic [3:0] m_retry [2];
    logic [3:0] m_clip  [2];
    logic [1:0] m_nen, m_nmute, m_fault;

    amp_supervisor #(
        .NUM_AMPS  (2),
        .TMR_W     (20),
        .T_ENABLE  (100),
        .T_MUTE    (50),
        .T_RETRY   (200),
        .ERR_FILT  (4),
        .MAX_RETRY (3),
        .CLIP_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .stream_lock  (stream_lock),
        .nerror_in    (nerror_in),
        .nclip_in     (nclip_in),
        .clip_clear   (clip_clear),
        .nenable_out  (nenable_out),
        .nmute_out    (nmute_out),
        .fault_out    (fault_out),
        .state_out    (state_out),
        .retry_out    (retry_out),
        .clip_cnt_out (clip_cnt_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ObsW-1:0] model_obs();
        return {m_state[1], m_state[0], m_nen, m_nmute, m_fault,
                m_retry[1], m_retry[0], m_clip[1], m_clip[0]};
    endfunction

    task automatic push(input int dly, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.obs  = model_obs();
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_states(input logic [2:0] s1, input logic [2:0] s0);
        m_state[1] = s1;
        m_state[0] = s0;
    endtask

    task automatic model_reset();
        set_states(3'd0, 3'd0);
        m_retry[0] = 4'd0;
        m_retry[1] = 4'd0;
        m_clip[0]  = 4'd0;
        m_clip[1]  = 4'd0;
        m_nen      = 2'b11;
        m_nmute    = 2'b00;
        m_fault    = 2'b00;
    endtask

    // Both amps from OFF to RUN: POWERUP next edge, enable one later, unmute 100 after.
    task automatic startup(input string tag);
        run = 1'b1;
        stream_lock = 1'b1;
        set_states(3'd1, 3'd1);
        push(1, {tag, "_powerup"});
        m_nen = 2'b00;
        push(2, {tag, "_enable"});
        set_states(3'd2, 3'd2);
        push(101, {tag, "_run"});
        m_nmute = 2'b11;
        push(102, {tag, "_unmute"});
        step(110);
    endtask

    task automatic clip_pulses(input int n, input logic [1:0] mask);
        for (int i = 0; i < n; i++) begin
            nclip_in = ~mask;
            step(2);
            nclip_in = 2'b11;
            step(2);
        end
    endtask

    // Monitor: each change of the packed outputs consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        logic [ObsW-1:0] obs;
        exp_t            e;
        obs = {state_out, nenable_out, nmute_out, fault_out, retry_out, clip_cnt_out};
        if (obs !== last_obs) begin
            last_obs = obs;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change",
                         obs, cyc);
            end else begin
                e = sb_q.pop_front();
                if (obs !== e.obs || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             e.name, obs, cyc, e.obs, e.cyc);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: outputs stayed %h at cycle %0d, required %h",
                     e.name, obs, cyc, e.obs);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] c0, c1;
        #1;
        model_reset();
        push(1, "reset_state");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step(2);

        startup("start");

        // 3-cycle error glitch on amp0 is filtered out: no output change expected.
        nerror_in[0] = 1'b0;
        step(3);
        nerror_in[0] = 1'b1;
        step(10);

        // 5-cycle error on amp0: RECOVER, then one retry back to RUN; amp1 untouched.
        m_state[0] = 3'd4;
        m_retry[0] = 4'd1;
        push(6, "err0_recover");
        m_nen = 2'b01;
        m_nmute = 2'b10;
        push(7, "err0_disable");
        m_state[0] = 3'd1;
        push(206, "err0_retry_powerup");
        m_nen = 2'b00;
        push(207, "err0_reenable");
        m_state[0] = 3'd2;
        push(306, "err0_run");
        m_nmute = 2'b11;
        push(307, "err0_unmute");
        nerror_in[0] = 1'b0;
        step(5);
        nerror_in[0] = 1'b1;
        step(310);

        // Persistent error on amp1: three RECOVER passes, then LATCHED with fault.
        nerror_in[1] = 1'b0;
        m_state[1] = 3'd4;
        m_retry[1] = 4'd1;
        push(6, "err1_recover1");
        m_nen = 2'b10;
        m_nmute = 2'b01;
        push(7, "err1_disable");
        m_state[1] = 3'd1;
        push(206, "err1_powerup2");
        m_state[1] = 3'd4;
        m_retry[1] = 4'd2;
        m_nen = 2'b00;
        push(207, "err1_recover2");
        m_nen = 2'b10;
        push(208, "err1_disable2");
        m_state[1] = 3'd1;
        push(407, "err1_powerup3");
        m_state[1] = 3'd4;
        m_retry[1] = 4'd3;
        m_nen = 2'b00;
        push(408, "err1_recover3");
        m_nen = 2'b10;
        push(409, "err1_disable3");
        m_state[1] = 3'd5;
        push(608, "err1_latched");
        m_fault = 2'b10;
        push(609, "err1_fault");
        step(620);

        // run=0: amp1 LATCHED->OFF clears fault/retry; amp0 RUN->MUTE->OFF.
        run = 1'b0;
        nerror_in[1] = 1'b1;
        set_states(3'd0, 3'd3);
        m_retry[1] = 4'd0;
        push(1, "stop_states");
        m_nmute = 2'b00;
        m_fault = 2'b00;
        push(2, "stop_mute_fault_clear");
        m_state[0] = 3'd0;
        m_retry[0] = 4'd0;
        push(51, "stop_amp0_off");
        m_nen = 2'b11;
        push(52, "stop_amp0_disable");
        step(60);

        startup("restart");

        // Lock loss in RUN, lock back during MUTE: complete to OFF, then restart.
        stream_lock = 1'b0;
        set_states(3'd3, 3'd3);
        push(1, "lock_mute_state");
        m_nmute = 2'b00;
        push(2, "lock_mute_pin");
        set_states(3'd0, 3'd0);
        push(51, "lock_off");
        set_states(3'd1, 3'd1);
        m_nen = 2'b11;
        push(52, "lock_repowerup");
        m_nen = 2'b00;
        push(53, "lock_reenable");
        set_states(3'd2, 3'd2);
        push(152, "lock_run");
        m_nmute = 2'b11;
        push(153, "lock_unmute");
        step(20);
        stream_lock = 1'b1;
        step(140);

        // Seven clip pulses on amp0.
        for (int i = 0; i < 7; i++) begin
            m_clip[0] = 4'(i + 1);
            push(4*i + 3, "clip_count");
        end
        clip_pulses(7, 2'b01);

        // Clear coincident with a clip edge leaves a count of one.
        nclip_in = 2'b10;
        m_clip[0] = 4'd1;
        push(3, "clip_clear_edge");
        step(2);
        clip_clear = 1'b1;
        nclip_in = 2'b11;
        step(1);
        clip_clear = 1'b0;
        step(3);

        // Twenty pulses on both amps saturate both counters at 15.
        for (int i = 0; i < 20; i++) begin
            c0 = (m_clip[0] == 4'd15) ? 4'd15 : m_clip[0] + 4'd1;
            c1 = (m_clip[1] == 4'd15) ? 4'd15 : m_clip[1] + 4'd1;
            if (c0 != m_clip[0] || c1 != m_clip[1]) begin
                m_clip[0] = c0;
                m_clip[1] = c1;
                push(4*i + 3, "clip_saturate");
            end
        end
        clip_pulses(20, 2'b11);
        step(4);

        // Asynchronous reset mid-RUN: outputs return to reset values before the next edge.
        reset = 1'b0;
        model_reset();
        push(0, "async_reset");
        run = 1'b0;
        stream_lock = 1'b0;
        step(3);
        reset = 1'b1;
        step(5);

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
